ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 65536, meaning storage size in bytes (power of two, >= 16).
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill all storage after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port i_ram_en  input  1  core data-bus access request.
REQ-006 SHALL have port i_ram_wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port i_ram_size  input  2  access size: `MEM_B byte, `MEM_H halfword, any other value word (def.v encodings).
REQ-008 SHALL have port i_ram_addr  input  32  byte address.
REQ-009 SHALL have port i_ram_wdata  input  32  write data, LSB-aligned.
REQ-010 SHALL have port o_ram_rdata  output  32  registered read data, zero-extended.
REQ-011 SHALL have port o_fault  output  1  one-cycle pulse marking a rejected access.
REQ-012 SHALL have port o_ready  output  1  high once storage is usable.
REQ-013 SHALL have port i_ld_en  input  1  loader word-write strobe.
REQ-014 SHALL have port i_ld_addr  input  32  loader byte address; bits [1:0] ignored.
REQ-015 SHALL have port i_ld_data  input  32  loader write word.

Function
REQ-016 SHALL store MEM_BYTES/4 words with four byte lanes, little-endian: byte address A maps to word A[..:2], bits [8*A[1:0]+7 : 8*A[1:0]].
REQ-017 SHALL implement FSM states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-018 In CLEAR, SHALL write zero to word index cnt each cycle, cnt 0..MEM_BYTES/4-1, then enter READY on the edge that writes the last word.
REQ-019 SHALL drive o_ready registered, high exactly when state is READY.
REQ-020 SHALL accept a core access when i_ram_en=1, state READY, i_ld_en=0, and no fault condition holds.
REQ-021 Writes SHALL update only: byte, lane A[1:0] from wdata[7:0]; halfword, lanes {A[1],0} and {A[1],1} from wdata[15:0]; word, all lanes from wdata[31:0].
REQ-022 Accepted reads SHALL update o_ram_rdata on the sampling edge (one-cycle latency): byte {24'b0,b}, halfword {16'b0,h}, word full; value held until the next accepted read or fault.
REQ-023 A read the cycle after a write to the same address SHALL return the new data.
REQ-024 Fault conditions: A >= MEM_BYTES; halfword with A[0]=1; word with A[1:0]!=0; i_ram_en while state CLEAR; i_ram_en together with i_ld_en.
REQ-025 On a fault SHALL suppress any write, load o_ram_rdata with 0, and assert o_fault for exactly the next cycle; back-to-back faults keep o_fault high.
REQ-026 Loader SHALL write i_ld_data to word i_ld_addr[..:2] in READY, with priority over the core; ignored in CLEAR; out-of-range loader addresses silently ignored.
REQ-027 Writes (core write, loader, non-accepted) SHALL NOT change o_ram_rdata.

Reset
REQ-028 On rst=1 at a rising edge: o_ram_rdata=0, o_fault=0, o_ready=0, cnt=0, state per REQ-017 (READY gives o_ready=1 next cycle); storage contents not reset except by CLEAR.
REQ-029 rst asserted mid-CLEAR SHALL restart clearing at word 0.

Verification
REQ-030 MEM_BYTES=64, CLEAR_ON_RESET=1, preloaded non-zero, release rst -> o_ready high after 16th edge; all words read 0x00000000.
REQ-031 Word write 0x89ABCDEF @0x10, byte read @0x11 -> 0x000000CD; halfword read @0x12 -> 0x000089AB; word read @0x10 -> 0x89ABCDEF, each one cycle after request.
REQ-032 Byte write 0x55 @0x13 over 0x89ABCDEF -> word read 0x55ABCDEF; halfword write 0x1234 @0x10 -> word read 0x55AB1234.
REQ-033 Halfword read @0x11, word write @0x12, access @MEM_BYTES -> o_fault pulse each, rdata 0, memory unchanged.
REQ-034 i_ld_en with 0xDEADBEEF @0x20 plus simultaneous core write 0x0 @0x20 -> o_fault pulse; word read @0x20 -> 0xDEADBEEF.
REQ-035 rst asserted at clear cycle 5 -> o_ready rises 16 edges after release; i_ram_en during CLEAR -> o_fault pulses.

Source files
------------

// File: rtl/ram_responder.sv
// Byte-addressable RAM responder for the core data bus, with a word-wide loader
// port and an optional zero-fill sweep after reset.
module ram_responder #(
   parameter int unsigned MEM_BYTES      = 65536,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ram_en,
   input  logic        i_ram_wr,
   input  logic [1:0]  i_ram_size,
   input  logic [31:0] i_ram_addr,
   input  logic [31:0] i_ram_wdata,
   output logic [31:0] o_ram_rdata,
   output logic        o_fault,
   output logic        o_ready,
   input  logic        i_ld_en,
   input  logic [31:0] i_ld_addr,
   input  logic [31:0] i_ld_data
);

   localparam int unsigned WORDS = MEM_BYTES / 4;
   localparam int unsigned AW    = $clog2(WORDS);
   localparam logic [31:0] LIMIT = 32'(MEM_BYTES);
   localparam logic [1:0]  SZ_B  = 2'd0;
   localparam logic [1:0]  SZ_H  = 2'd1;

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t            r_state, w_state_nxt;
   logic [AW-1:0]     r_cnt;
   logic              r_ready;
   logic              r_fault;
   logic [31:0]       r_rdata;
   logic [3:0][7:0]   r_mem [WORDS];

   logic              w_misalign;
   logic              w_fault;
   logic              w_acc;
   logic              w_ld_ok;
   logic              w_we;
   logic [3:0]        w_be;
   logic [AW-1:0]     w_widx;
   logic [3:0][7:0]   w_wdat;
   logic [3:0][7:0]   w_rword;
   logic [31:0]       w_rval;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == S_READY);
         if (r_state == S_CLEAR)
            r_cnt <= r_cnt + AW'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_CLEAR && r_cnt == AW'(WORDS - 1))
         w_state_nxt = S_READY;
   end

   always_comb begin
      w_misalign = 1'b0;
      case (i_ram_size)
         SZ_B:    w_misalign = 1'b0;
         SZ_H:    w_misalign = i_ram_addr[0];
         default: w_misalign = |i_ram_addr[1:0];
      endcase
      w_fault = i_ram_en && (r_state == S_CLEAR || i_ld_en ||
                             i_ram_addr >= LIMIT || w_misalign);
      w_acc   = i_ram_en && !w_fault;
      w_ld_ok = i_ld_en && r_state == S_READY && i_ld_addr < LIMIT;
   end

   // Single write port shared by the clear sweep, the loader and the core;
   // core data is replicated across lanes so the byte enables pick the slot.
   always_comb begin
      w_we   = 1'b0;
      w_be   = '0;
      w_widx = i_ram_addr[AW+1:2];
      w_wdat = i_ram_wdata;
      if (r_state == S_CLEAR) begin
         w_we   = 1'b1;
         w_be   = '1;
         w_widx = r_cnt;
         w_wdat = '0;
      end else if (w_ld_ok) begin
         w_we   = 1'b1;
         w_be   = '1;
         w_widx = i_ld_addr[AW+1:2];
         w_wdat = i_ld_data;
      end else if (w_acc && i_ram_wr) begin
         w_we = 1'b1;
         case (i_ram_size)
            SZ_B: begin
               w_be   = 4'b0001 << i_ram_addr[1:0];
               w_wdat = {4{i_ram_wdata[7:0]}};
            end
            SZ_H: begin
               w_be   = i_ram_addr[1] ? 4'b1100 : 4'b0011;
               w_wdat = {2{i_ram_wdata[15:0]}};
            end
            default: w_be = '1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_we && !rst) begin
         for (int unsigned l = 0; l < 4; l++)
            if (w_be[l])
               r_mem[w_widx][l] <= w_wdat[l];
      end
   end

   always_comb begin
      w_rword = r_mem[i_ram_addr[AW+1:2]];
      case (i_ram_size)
         SZ_B:    w_rval = {24'b0, w_rword[i_ram_addr[1:0]]};
         SZ_H:    w_rval = i_ram_addr[1] ? {16'b0, w_rword[3], w_rword[2]}
                                         : {16'b0, w_rword[1], w_rword[0]};
         default: w_rval = w_rword;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_fault <= 1'b0;
      end else begin
         r_fault <= w_fault;
         if (w_fault)
            r_rdata <= '0;
         else if (w_acc && !i_ram_wr)
            r_rdata <= w_rval;
      end
   end

   assign o_ram_rdata = r_rdata;
   assign o_fault     = r_fault;
   assign o_ready     = r_ready;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: a byte-array model predicts read data and
// fault pulses, which are queued at drive time and compared one cycle later.
module tb_ram_responder;

   localparam int unsigned MB = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_ram_en = 1'b0;
   logic        i_ram_wr = 1'b0;
   logic [1:0]  i_ram_size = 2'd0;
   logic [31:0] i_ram_addr = '0;
   logic [31:0] i_ram_wdata = '0;
   logic [31:0] o_ram_rdata;
   logic        o_fault;
   logic        o_ready;
   logic        i_ld_en = 1'b0;
   logic [31:0] i_ld_addr = '0;
   logic [31:0] i_ld_data = '0;

   ram_responder #(.MEM_BYTES(MB), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst),
      .i_ram_en(i_ram_en), .i_ram_wr(i_ram_wr), .i_ram_size(i_ram_size),
      .i_ram_addr(i_ram_addr), .i_ram_wdata(i_ram_wdata),
      .o_ram_rdata(o_ram_rdata), .o_fault(o_fault), .o_ready(o_ready),
      .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data)
   );

   always #5 clk = ~clk;

   int unsigned edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   typedef struct {
      logic [31:0] rd;
      logic        flt;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  mdl[MB];
   bit          mdl_ready = 1'b0;
   logic [31:0] hold = '0;
   int          n_vec = 0;
   int          n_mis = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_rd"}, o_ram_rdata, e.rd);
         check({tag, "_flt"}, {31'b0, o_fault}, {31'b0, e.flt});
      end
   endtask

   task automatic model_load(input logic [31:0] la, input logic [31:0] ld);
      if (mdl_ready && la < MB) begin
         for (int b = 0; b < 4; b++)
            mdl[{la[5:2], 2'(b)}] = ld[8*b +: 8];
      end
   endtask

   task automatic access(input string tag, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit ld = 1'b0, input logic [31:0] la = '0,
                         input logic [31:0] ldd = '0);
      exp_t e;
      bit   flt;
      flt = !mdl_ready || ld || a >= MB || (sz == 2'd1 && a[0]) ||
            (sz >= 2'd2 && a[1:0] != 2'd0);
      if (ld) model_load(la, ldd);
      e.flt = flt;
      if (flt) begin
         hold = '0;
         e.rd = '0;
      end else if (wr) begin
         case (sz)
            2'd0: mdl[a[5:0]] = wd[7:0];
            2'd1: begin
               mdl[a[5:0]]        = wd[7:0];
               mdl[a[5:0] + 6'd1] = wd[15:8];
            end
            default: for (int b = 0; b < 4; b++) mdl[{a[5:2], 2'(b)}] = wd[8*b +: 8];
         endcase
         e.rd = hold;
      end else begin
         case (sz)
            2'd0: hold = {24'b0, mdl[a[5:0]]};
            2'd1: hold = {16'b0, mdl[a[5:0] + 6'd1], mdl[a[5:0]]};
            default: hold = {mdl[{a[5:2], 2'd3}], mdl[{a[5:2], 2'd2}],
                             mdl[{a[5:2], 2'd1}], mdl[{a[5:2], 2'd0}]};
         endcase
         e.rd = hold;
      end
      @(negedge clk);
      i_ram_en = 1'b1; i_ram_wr = wr; i_ram_size = sz;
      i_ram_addr = a;  i_ram_wdata = wd;
      i_ld_en = ld;    i_ld_addr = la; i_ld_data = ldd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_check(tag);
      i_ram_en = 1'b0;
      i_ld_en  = 1'b0;
   endtask

   task automatic loader(input logic [31:0] la, input logic [31:0] ldd);
      exp_t e;
      model_load(la, ldd);
      e.rd  = hold;
      e.flt = 1'b0;
      @(negedge clk);
      i_ld_en = 1'b1; i_ld_addr = la; i_ld_data = ldd;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_check("ld");
      i_ld_en = 1'b0;
   endtask

   task automatic idle(input string tag);
      exp_t e;
      e.rd  = hold;
      e.flt = 1'b0;
      @(negedge clk);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      pop_check(tag);
   endtask

   task automatic reset_and_clear(input int unsigned mid);
      int unsigned start;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rd", o_ram_rdata, '0);
      check("rst_flt", {31'b0, o_fault}, '0);
      check("rst_rdy", {31'b0, o_ready}, '0);
      hold = '0;
      mdl_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      start = edge_cnt;
      if (mid > 0) begin
         repeat (mid) @(posedge clk);
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1;
         check("mid_rdy", {31'b0, o_ready}, '0);
         @(negedge clk);
         rst = 1'b0;
         start = edge_cnt;
      end else begin
         access("clr_acc", 1'b0, 2'd2, 32'h0, '0);
      end
      do begin
         @(posedge clk);
         #1;
      end while (!o_ready && edge_cnt - start < 64);
      check("rdy_edges", edge_cnt - start, 32'd16);
      mdl_ready = 1'b1;
      for (int i = 0; i < MB; i++) mdl[i] = 8'h00;
   endtask

   initial begin
      for (int i = 0; i < MB; i++) mdl[i] = 8'h00;
      repeat (2) @(posedge clk);

      reset_and_clear(0);
      for (int i = 0; i < 16; i++) loader(32'(i * 4), 32'hA5A50000 | 32'(i));
      loader(32'd64, 32'hFFFFFFFF);
      access("pre_w0", 1'b0, 2'd2, 32'h00, '0);
      access("pre_w15", 1'b0, 2'd2, 32'h3C, '0);

      reset_and_clear(0);
      for (int i = 0; i < 16; i++) access("clr_rd", 1'b0, 2'd2, 32'(i * 4), '0);

      access("w_word", 1'b1, 2'd2, 32'h10, 32'h89ABCDEF);
      access("r_b11", 1'b0, 2'd0, 32'h11, '0);
      access("r_h12", 1'b0, 2'd1, 32'h12, '0);
      access("r_w10", 1'b0, 2'd2, 32'h10, '0);
      access("w_b13", 1'b1, 2'd0, 32'h13, 32'hFFFFFF55);
      access("r_w10b", 1'b0, 2'd2, 32'h10, '0);
      access("w_h10", 1'b1, 2'd1, 32'h10, 32'hFFFF1234);
      access("r_w10h", 1'b0, 2'd3, 32'h10, '0);
      access("r_b12", 1'b0, 2'd0, 32'h12, '0);

      access("f_h11", 1'b0, 2'd1, 32'h11, '0);
      access("f_w12", 1'b1, 2'd2, 32'h12, 32'hFFFFFFFF);
      access("f_oob", 1'b0, 2'd2, MB, '0);
      idle("post_f");
      access("f_chk", 1'b0, 2'd2, 32'h10, '0);
      access("f_chk14", 1'b0, 2'd2, 32'h14, '0);

      access("ld_core", 1'b1, 2'd2, 32'h20, 32'h0, 1'b1, 32'h20, 32'hDEADBEEF);
      access("r_w20", 1'b0, 2'd2, 32'h20, '0);
      access("w_hold", 1'b1, 2'd0, 32'h3F, 32'h77);
      loader(32'h24, 32'h01020304);
      access("r_b23", 1'b0, 2'd0, 32'h23, '0);
      access("r_h22", 1'b0, 2'd1, 32'h22, '0);
      access("r_b3f", 1'b0, 2'd0, 32'h3F, '0);
      access("r_w24", 1'b0, 2'd2, 32'h24, '0);

      reset_and_clear(5);
      access("mid_w0", 1'b0, 2'd2, 32'h00, '0);
      access("mid_w10", 1'b0, 2'd2, 32'h10, '0);
      access("mid_w20", 1'b0, 2'd2, 32'h20, '0);
      access("mid_w3c", 1'b0, 2'd2, 32'h3C, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
